// File: rtl/pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pic_inta_sequencer
// Purpose : 8086-mode two-pulse INTA sequencer for an 8259A PIC; captures the
//           vector byte and hands it to the CPU over valid/ready.
// Option  : define PIC_ACK_BUFFER_EN for a 2-entry vector FIFO on the output.
// Revision: 1.0 - initial release
// ============================================================================
module pic_inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 4,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int RECOVER_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pic_int,
    output logic       pic_inta_n,
    input  logic [7:0] pic_data,
    input  logic       cpu_ie,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    output logic       spurious
);

    localparam logic [7:0] c_low_cycles     = 8'(INTA_LOW_CYCLES);
    localparam logic [7:0] c_gap_cycles     = 8'(INTA_GAP_CYCLES);
    localparam logic [7:0] c_recover_cycles = 8'(RECOVER_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P1      = 3'd1,
        S_GAP     = 3'd2,
        S_P2      = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_inta_n;
    logic                   r_spurious;
    logic [7:0]             r_vec_data;
    logic                   r_vec_valid;

    logic w_int_s;
    logic w_int_s_next;
    logic w_capture;
    logic w_pop;
    logic w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pic_int};
        end
    end

    // w_int_s_next is what int_s will be one cycle from now
    assign w_int_s      = r_sync[SYNC_STAGES-1];
    assign w_int_s_next = r_sync[SYNC_STAGES-2];
    assign w_capture    = (r_state == S_P2) && (r_cnt == 8'd1);
    assign w_pop        = r_vec_valid && vec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_inta_n   <= 1'b1;
            r_spurious <= 1'b0;
        end else begin
            // Raised so that it coincides with the last P1 cycle
            r_spurious <= (r_state == S_P1) && (r_cnt == 8'd2) && !w_int_s_next;
            case (r_state)
                S_IDLE: begin
                    if (w_int_s && cpu_ie && !w_full) begin
                        r_state  <= S_P1;
                        r_cnt    <= c_low_cycles;
                        r_inta_n <= 1'b0;
                    end
                end
                S_P1: begin
                    if (r_cnt == 8'd1) begin
                        r_state  <= S_GAP;
                        r_cnt    <= c_gap_cycles;
                        r_inta_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 8'd1) begin
                        r_state  <= S_P2;
                        r_cnt    <= c_low_cycles;
                        r_inta_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_P2: begin
                    if (r_cnt == 8'd1) begin
                        r_state  <= S_RECOVER;
                        r_cnt    <= c_recover_cycles;
                        r_inta_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == 8'd1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= 8'd0;
                    r_inta_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIC_ACK_BUFFER_EN
    logic [7:0] r_tail;
    logic [1:0] r_count;

    // r_vec_data is the FIFO head; a full FIFO never sees a capture since IDLE blocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_data  <= 8'h00;
            r_tail      <= 8'h00;
            r_count     <= 2'd0;
            r_vec_valid <= 1'b0;
        end else begin
            case ({w_capture, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_vec_data <= pic_data;
                    end else begin
                        r_tail <= pic_data;
                    end
                    r_count     <= r_count + 2'd1;
                    r_vec_valid <= 1'b1;
                end
                2'b01: begin
                    r_vec_data  <= r_tail;
                    r_count     <= r_count - 2'd1;
                    r_vec_valid <= (r_count == 2'd2);
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_vec_data <= pic_data;
                    end else begin
                        r_vec_data <= r_tail;
                        r_tail     <= pic_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_full = (r_count == 2'd2);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_data  <= 8'h00;
            r_vec_valid <= 1'b0;
        end else if (w_capture) begin
            r_vec_data  <= pic_data;
            r_vec_valid <= 1'b1;
        end else if (w_pop) begin
            r_vec_valid <= 1'b0;
        end
    end

    assign w_full = r_vec_valid;
`endif

    assign pic_inta_n = r_inta_n;
    assign spurious   = r_spurious;
    assign vec_valid  = r_vec_valid;
    assign vec_data   = r_vec_data;

endmodule
`default_nettype wire

// File: tb/tb_pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pic_inta_sequencer
// Purpose : Directed bench for pic_inta_sequencer; vectors go through a
//           scoreboard queue, handshake timing is checked cycle by cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pic_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pic_int;
    logic       pic_inta_n;
    logic [7:0] pic_data;
    logic       cpu_ie;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       vec_ready;
    logic       spurious;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    pic_inta_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pic_int    (pic_int),
        .pic_inta_n (pic_inta_n),
        .pic_data   (pic_data),
        .cpu_ie     (cpu_ie),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_ready  (vec_ready),
        .spurious   (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted vector must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vec_valid === 1'b1 && vec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h want none", vec_data);
            end else begin
                check("sb_vec", {24'd0, vec_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input string name);
        int n;
        n = 0;
        while (pic_inta_n !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        if (pic_inta_n !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s: got no INTA want INTA within 20 cycles", name);
        end
    endtask

    // pic_int rises now; INTA must fall on the third edge
    task automatic latency_check(input string name);
        pic_int = 1'b1;
        step();
        check({name, "_lat1"}, {31'd0, pic_inta_n}, 32'd1);
        step();
        check({name, "_lat2"}, {31'd0, pic_inta_n}, 32'd1);
        step();
        check({name, "_lat3"}, {31'd0, pic_inta_n}, 32'd0);
    endtask

    // Entered on the first P1 cycle; walks both pulses up to the first RECOVER cycle
    task automatic do_sequence(input logic [7:0] v, input int drop_at, input bit drop_ie);
        logic exp_inta;
        logic exp_spur;
        exp_q.push_back(v);
        for (int i = 1; i <= 11; i++) begin
            if (i > 1) step();
            exp_inta = (i <= 4 || (i >= 7 && i <= 10)) ? 1'b0 : 1'b1;
            exp_spur = (i == 4) && (drop_at <= 2);
            check($sformatf("inta_n_%0h_%0d", v, i), {31'd0, pic_inta_n}, {31'd0, exp_inta});
            check($sformatf("spurious_%0h_%0d", v, i), {31'd0, spurious}, {31'd0, exp_spur});
            if (i == drop_at) pic_int = 1'b0;
            if (i == 3 && drop_ie) cpu_ie = 1'b0;
            if (i == 10) pic_data = v;
            if (i == 11) begin
                pic_data = 8'hFF;
                check($sformatf("valid_%0h", v), {31'd0, vec_valid}, 32'd1);
            end
        end
        cpu_ie = 1'b1;
    endtask

    task automatic count_lows(input string name, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (pic_inta_n !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    initial begin
        int lows;
        int valids;
        rst_n     = 1'b0;
        pic_int   = 1'b1;
        pic_data  = 8'hFF;
        cpu_ie    = 1'b1;
        vec_ready = 1'b1;

        // Reset held with INT asserted
        lows = 0;
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (pic_inta_n !== 1'b1) lows++;
            if (vec_valid !== 1'b0 || spurious !== 1'b0) valids++;
        end
        check("rst_inta", lows, 0);
        check("rst_valid_spur", valids, 0);
        check("rst_vec_data", {24'd0, vec_data}, 32'h00);

        // cpu_ie low: INT ignored for 50 cycles, then INTA one cycle after enabling
        cpu_ie = 1'b0;
        rst_n  = 1'b1;
        count_lows("ie_off_no_inta", 50);
        cpu_ie = 1'b1;
        step();
        check("ie_on_fall", {31'd0, pic_inta_n}, 32'd0);
        do_sequence(8'h3C, 7, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Basic sequence with latency and single-cycle valid
        latency_check("basic");
        do_sequence(8'h48, 7, 1'b0);
        step();
        check("basic_valid_drop", {31'd0, vec_valid}, 32'd0);
        count_lows("basic_idle", 6);

        // INT lost in P1 cycle 2 and cpu_ie dropped: sequence still completes
        pic_int = 1'b1;
        wait_fall("spur_start");
        do_sequence(8'h4F, 2, 1'b1);
        count_lows("spur_idle", 6);

        // Back-pressure with INT held high
        vec_ready = 1'b0;
        pic_int   = 1'b1;
        wait_fall("bp_start1");
        do_sequence(8'h40, 99, 1'b0);
`ifdef PIC_ACK_BUFFER_EN
        wait_fall("bp_start2");
        do_sequence(8'h41, 99, 1'b0);
        count_lows("bp_stall", 30);
        check("bp_head", {24'd0, vec_data}, 32'h40);
        pic_int = 1'b0;
        for (int i = 0; i < 3; i++) step();
        vec_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
`else
        count_lows("bp_stall", 30);
        check("bp_held_valid", {31'd0, vec_valid}, 32'd1);
        check("bp_head", {24'd0, vec_data}, 32'h40);
        vec_ready = 1'b1;
        wait_fall("bp_start2");
        do_sequence(8'h41, 7, 1'b0);
        for (int i = 0; i < 6; i++) step();
`endif

        // Reset during P2 cycle 2
        latency_check("rst_mid");
        for (int i = 2; i <= 8; i++) step();
        check("rst_mid_p2_low", {31'd0, pic_inta_n}, 32'd0);
        pic_data = 8'h77;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_inta", {31'd0, pic_inta_n}, 32'd1);
        check("rst_mid_valid", {31'd0, vec_valid}, 32'd0);
        pic_int  = 1'b0;
        pic_data = 8'hFF;
        step();
        step();
        rst_n = 1'b1;
        valids = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vec_valid !== 1'b0) valids++;
        end
        check("rst_mid_no_valid", valids, 0);
        latency_check("after_rst");
        do_sequence(8'h5A, 7, 1'b0);
        for (int i = 0; i < 6; i++) step();

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
